display_scan_ctrl: RTL

//  Time-multiplexed driver for an N-digit 7-segment display with its own refresh timing.

---
 rtl/display_scan_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Time-multiplexed scan driver for an N-digit 7-segment display.
//               Each scan slot presents one digit code and a one-hot active-low
//               anode, blanked for the first BLANK_CYCLES of the slot to avoid
//               ghosting. It marks the edit-position pointer in the program
//               states selected by PTR_STATE_MASK, can blink the pointed digit,
//               and can suppress leading zeros.
// Ports       : clk              - system clock, rising edge
//               reset            - asynchronous, active-high
//               state            - program state (selects pointer visibility)
//               digits           - packed digit codes, digit 0 is rightmost
//               position_pointer - index of the edit-position digit
//               blink_en         - blink the pointed digit
//               one_digit        - code of the digit in the current slot
//               digit_idx        - index of the current slot
//               anode_n          - one-hot active-low digit enable
//               pointer_now      - show pointer/decimal point on this digit
//               frame_tick       - one-cycle pulse when the slot index wraps
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int         NUM_DIGITS     = 8,
    parameter int         DIGIT_W        = 4,
    parameter int         PTR_W          = 3,
    parameter int         REFRESH_DIV    = 50000,
    parameter int         BLANK_CYCLES   = 500,
    parameter int         BLINK_FRAMES   = 64,
    parameter logic [7:0] PTR_STATE_MASK = 8'h0B,
    parameter bit         LZ_BLANK       = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    state,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    input  logic [PTR_W-1:0]              position_pointer,
    input  logic                          blink_en,
    output logic [DIGIT_W-1:0]            one_digit,
    output logic [PTR_W-1:0]              digit_idx,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic                          pointer_now,
    output logic                          frame_tick
);

    localparam int c_slot_w  = $clog2(NUM_DIGITS);
    localparam int c_presc_w = $clog2(REFRESH_DIV);
    localparam int c_frame_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_presc_w-1:0]  c_presc_last = c_presc_w'(REFRESH_DIV - 1);
    localparam logic [c_presc_w-1:0]  c_blank_end  = c_presc_w'(BLANK_CYCLES);
    localparam logic [c_slot_w-1:0]   c_slot_last  = c_slot_w'(NUM_DIGITS - 1);
    localparam logic [c_frame_w-1:0]  c_frame_last = c_frame_w'(BLINK_FRAMES - 1);
    localparam logic [PTR_W:0]        c_num_digits = (PTR_W + 1)'(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] c_anode_lsb  = NUM_DIGITS'(1);

    // ------------------------------------------------------------------------
    // Scan timing: prescaler -> slot -> frame -> blink phase
    // ------------------------------------------------------------------------
    logic [c_presc_w-1:0] r_presc;
    logic [c_slot_w-1:0]  r_slot;
    logic [c_frame_w-1:0] r_frame;
    logic                 r_blink_phase;

    logic w_presc_wrap;
    logic w_slot_wrap;
    logic w_frame_end;

    assign w_presc_wrap = (r_presc == c_presc_last);
    assign w_slot_wrap  = (r_slot == c_slot_last);
    assign w_frame_end  = w_presc_wrap && w_slot_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc       <= '0;
            r_slot        <= '0;
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_presc_wrap) begin
                r_presc <= '0;
                r_slot  <= w_slot_wrap ? '0 : r_slot + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_frame_end) begin
                if (r_frame == c_frame_last) begin
                    r_frame       <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Digit selection, pointer and leading-zero decisions for the current slot
    // ------------------------------------------------------------------------
    logic [DIGIT_W-1:0]    w_digit_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_lz_vec;
    logic [PTR_W-1:0]      w_slot_ext;
    logic                  w_ptr_act;
    logic                  w_ptr_hit;
    logic                  w_lz_blank;
    logic                  w_blink_off;
    logic                  w_anode_on;
    logic [NUM_DIGITS-1:0] w_anode_next;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_unpack
        assign w_digit_arr[k] = digits[k*DIGIT_W +: DIGIT_W];
    end

    // Walk from the most significant digit downwards: a digit is a leading
    // zero candidate while it and everything above it are zero. Digit 0 is
    // always shown so an all-zero value still displays "0".
    always_comb begin
        logic v_upper_zero;
        v_upper_zero = 1'b1;
        w_lz_vec     = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_upper_zero = v_upper_zero && (w_digit_arr[k] == '0);
            w_lz_vec[k]  = v_upper_zero && (k != 0);
        end
    end

    assign w_slot_ext  = PTR_W'(r_slot);
    // Out-of-range pointers never mark a digit.
    assign w_ptr_act   = PTR_STATE_MASK[state] && ({1'b0, position_pointer} < c_num_digits);
    assign w_ptr_hit   = w_ptr_act && (w_slot_ext == position_pointer);
    // The pointed digit stays visible even if it is a leading zero.
    assign w_lz_blank  = LZ_BLANK && w_lz_vec[r_slot] && !w_ptr_hit;
    assign w_blink_off = blink_en && w_ptr_hit && r_blink_phase;
    assign w_anode_on  = (r_presc >= c_blank_end) && !w_lz_blank && !w_blink_off;

    assign w_anode_next = w_anode_on ? ~(c_anode_lsb << r_slot) : '1;

    // ------------------------------------------------------------------------
    // Registered outputs: all change together, one cycle after the counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            one_digit   <= '0;
            digit_idx   <= '0;
            anode_n     <= '1;
            pointer_now <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            one_digit   <= w_digit_arr[r_slot];
            digit_idx   <= w_slot_ext;
            anode_n     <= w_anode_next;
            pointer_now <= w_ptr_hit;
            frame_tick  <= w_frame_end;
        end
    end

endmodule
`default_nettype wire
